conv_result_collector: RTL
==========================

// Module: conv_result_collector
// PURPOSE
//  Sink for the raster stream leaving the convolutor. Tracks each sample's pixel position,
//  drops border/wrap-around outputs whose KxK window is incomplete, and forwards only the
//  (N-K+1)^2 valid results per frame on a valid/ready stream through a small FIFO.
//  Provides in_ready so the pixel feeder can throttle en.
// PARAMETERS
//  N           4   image width = height (pixels), must match convolutor
//  DATA_WIDTH  16  sample width (two's complement)
//  K_SIZE      3   kernel size, must match convolutor
//  LATENCY     1   en-qualified samples between pixel entering convolutor and its result on data_i
//  FIFO_DEPTH  4   output FIFO entries, power of 2, >= 2
// PORTS
//  clk       in   1           clock, rising edge
//  rst_n     in   1           asynchronous reset, active-low
//  en        in   1           sample strobe, same signal driving convolutor en
//  data_i    in   DATA_WIDTH  convolutor data_o
//  in_ready  out  1           upstream may assert en next cycle
//  m_valid   out  1           m_data holds a valid result
//  m_ready   in   1           downstream accepts result
//  m_data    out  DATA_WIDTH  valid convolution result, raster order
//  m_last    out  1           with m_valid: last result of a frame (pixel row N-1, col N-1)
//  overflow  out  1           sticky: a valid result was dropped because FIFO was full
// BEHAVIOUR
//  Reset (rst_n=0, async): warm-up count, row, col, FIFO pointers cleared; m_valid=0,
//   m_data=0, m_last=0, overflow=0, in_ready=1.
//  States: WARMUP -> RUN. WARMUP: first LATENCY en samples discarded (pipeline fill),
//   then RUN. LATENCY=0 starts directly in RUN. No return to WARMUP except reset.
//  RUN: each en sample maps to pixel (row,col); col++ per sample, wraps N-1->0 with row++;
//   row wraps N-1->0 at col wrap; frames run back-to-back, no gap.
//  Sample is valid iff row >= K_SIZE-1 and col >= K_SIZE-1; others discarded silently.
//  Cycles with en=0: no counter change, data_i ignored.
//  Valid sample -> FIFO write of {last, data}; last = (row==N-1 && col==N-1).
//  FIFO show-ahead: m_valid = !empty, m_data/m_last = head entry.
//   Latency: valid en sample on cycle t -> m_valid on t+1 when FIFO was empty.
//  Pop on m_valid && m_ready. Push and pop same cycle: both happen, count unchanged,
//   allowed even when full.
//  Full without pop: valid sample dropped, overflow set to 1 until reset; counters still advance
//   so later positions stay correct.
//  m_data/m_last stable while m_valid && !m_ready.
//  in_ready registered: 1 when free entries after this cycle's push/pop >= 2, else 0.
//   Upstream must honour it, but collector never stalls counters itself.
//  Arithmetic: counters sized $clog2(N), fill counter $clog2(LATENCY+1); no data arithmetic
//   except the optional clamp.
// CONFIGURATION
//  CONV_COLLECT_RELU_EN defined: data_i treated as signed; negative valid results written
//   as 0 (ReLU), others unchanged.
//  Not defined: data_i passed through bit-exact.
//  Position and overflow logic identical in both builds.
// TESTING (N=4, K_SIZE=3, LATENCY=1, FIFO_DEPTH=4, m_ready=1 unless stated)
//  1. en=1 for 17 cycles, data_i=0..16 -> outputs 11,12,15,16 in order; m_last only with 16;
//     no other m_valid.
//  2. Case 1 with en toggled 1/0 each cycle -> same 4 outputs/order; counters frozen on en=0.
//  3. Two frames back-to-back, 33 samples 0..32 -> 11,12,15,16,27,28,31,32;
//     m_last with 16 and 32.
//  4. m_ready=0 through frame 1 -> FIFO holds 4, in_ready=0 after 3rd push, overflow=0;
//     release -> 11,12,15,16 drained.
//  5. m_ready=0 over 2 frames -> 5th valid result (27) dropped, overflow=1 and sticky;
//     drain yields 11,12,15,16.
//  6. rst_n low mid-frame (after sample 12) -> all outputs at reset values immediately;
//     re-run case 1 -> identical output.
//     With CONV_COLLECT_RELU_EN: data_i=16'hFFF0 at pixel 10 -> m_data=0.

Source files
------------

// File: rtl/conv_result_collector.sv
// ---------------------------------------------------------------------------
// conv_result_collector
//   Sink for the raster stream produced by the convolutor. It follows the
//   pixel position of every en-qualified sample, throws away border and
//   wrap-around results whose KxK window is incomplete, and queues the valid
//   results (plus an end-of-frame flag) in a small show-ahead FIFO drained
//   over a valid/ready stream.
//
//   Optional build macro: CONV_COLLECT_RELU_EN
//     defined   : data_i is signed; negative valid results are written as 0.
//     undefined : data_i is forwarded bit-exact.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   en        in   sample strobe (same strobe that drives the convolutor)
//   data_i    in   convolutor output sample
//   in_ready  out  registered: upstream may assert en next cycle
//   m_valid   out  m_data/m_last hold a result
//   m_ready   in   downstream accepts the current result
//   m_data    out  valid convolution result, raster order
//   m_last    out  last result of a frame (pixel N-1,N-1)
//   overflow  out  sticky: a valid result was lost to a full FIFO
// ---------------------------------------------------------------------------
module conv_result_collector #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 16,
  parameter int K_SIZE     = 3,
  parameter int LATENCY    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  in_ready,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  overflow
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {S_WARMUP, S_RUN} state_t;

  state_t              r_state;
  logic [FW-1:0]       r_fill;
  logic [CW-1:0]       r_row;
  logic [CW-1:0]       r_col;
  logic [DATA_WIDTH:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr;
  logic [AW-1:0]       r_rd;
  logic [NW-1:0]       r_cnt;
  logic                r_ovf;
  logic                r_in_ready;

  logic                  w_pos_ok;
  logic                  w_last;
  logic                  w_sample;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [NW-1:0]         w_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_wdata;

  // Window is complete only once K_SIZE-1 rows and columns have been seen.
  assign w_pos_ok = (r_row >= CW'(K_SIZE - 1)) && (r_col >= CW'(K_SIZE - 1));
  assign w_last   = (r_row == CW'(N - 1)) && (r_col == CW'(N - 1));
  assign w_sample = en && (r_state == S_RUN) && w_pos_ok;
  assign w_full   = (r_cnt == NW'(FIFO_DEPTH));
  assign w_pop    = (r_cnt != '0) && m_ready;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign w_push   = w_sample && (!w_full || w_pop);
  assign w_drop   = w_sample && w_full && !w_pop;

`ifdef CONV_COLLECT_RELU_EN
  assign w_wdata = data_i[DATA_WIDTH-1] ? '0 : data_i;
`else
  assign w_wdata = data_i;
`endif

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop)
      w_cnt_nxt = r_cnt + NW'(1);
    else if (!w_push && w_pop)
      w_cnt_nxt = r_cnt - NW'(1);
  end

  // Position tracker: pipeline warm-up, then raster row/col per en sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= (LATENCY == 0) ? S_RUN : S_WARMUP;
      r_fill  <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else if (en) begin
      case (r_state)
        S_WARMUP: begin
          if (r_fill == FW'(LATENCY - 1))
            r_state <= S_RUN;
          else
            r_fill <= r_fill + FW'(1);
        end
        default: begin
          if (r_col == CW'(N - 1)) begin
            r_col <= '0;
            r_row <= (r_row == CW'(N - 1)) ? '0 : r_row + CW'(1);
          end else begin
            r_col <= r_col + CW'(1);
          end
        end
      endcase
    end
  end

  // FIFO control, sticky overflow and registered in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) r_wr <= (r_wr == AW'(FIFO_DEPTH - 1)) ? '0 : r_wr + AW'(1);
      if (w_pop)  r_rd <= (r_rd == AW'(FIFO_DEPTH - 1)) ? '0 : r_rd + AW'(1);
      r_cnt      <= w_cnt_nxt;
      if (w_drop) r_ovf <= 1'b1;
      r_in_ready <= (w_cnt_nxt <= NW'(FIFO_DEPTH - 2));
    end
  end

  // FIFO storage holds data only; no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {w_last, w_wdata};
  end

  // Show-ahead head; forced to zero while empty so reset clears the outputs.
  assign m_valid  = (r_cnt != '0);
  assign m_data   = m_valid ? r_mem[r_rd][DATA_WIDTH-1:0] : '0;
  assign m_last   = m_valid ? r_mem[r_rd][DATA_WIDTH] : 1'b0;
  assign overflow = r_ovf;
  assign in_ready = r_in_ready;

endmodule
